// File: rtl/ps2_rx_decoder.sv
// PS/2 keyboard receiver: synchronises and deglitches the pins, decodes 11-bit frames,
// folds E0/F0 prefixes into flags and queues key events in a fall-through FIFO.
module ps2_rx_decoder #(
  parameter int SYNC_STAGES    = 2,
  parameter int FILTER_LEN     = 4,
  parameter int TIMEOUT_CYCLES = 50000,
  parameter int FIFO_DEPTH     = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          key_clock,
  input  logic                          data,
  output logic                          event_valid,
  input  logic                          event_ready,
  output logic [7:0]                    event_code,
  output logic                          event_break,
  output logic                          event_ext,
  output logic                          frame_error,
  output logic [7:0]                    error_count,
  output logic                          overflow,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  localparam int FCW = $clog2(FILTER_LEN + 1);
  localparam int TCW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int PW  = $clog2(FIFO_DEPTH);
  localparam int LW  = PW + 1;

  typedef enum logic [1:0] {IDLE, SHIFT, CHECK} state_t;

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  // Stage 0: synchronisers, idle-high so reset never fakes a falling edge
  logic [SYNC_STAGES-1:0] kclk_sync_p0, data_sync_p0;
  logic                   kclk_s, data_s;

  always_ff @(posedge clk) begin
    if (reset) begin
      kclk_sync_p0 <= '1;
      data_sync_p0 <= '1;
    end else begin
      kclk_sync_p0 <= {kclk_sync_p0[SYNC_STAGES-2:0], key_clock};
      data_sync_p0 <= {data_sync_p0[SYNC_STAGES-2:0], data};
    end
  end

  assign kclk_s = kclk_sync_p0[SYNC_STAGES-1];
  assign data_s = data_sync_p0[SYNC_STAGES-1];

  // Stage 1: level filter; fall is asserted in the cycle the filtered clock drops
  logic           filt_clk_p1;
  logic [FCW-1:0] filt_cnt_p1;
  logic           filt_switch, fall;

  assign filt_switch = (kclk_s != filt_clk_p1) && (filt_cnt_p1 == FCW'(FILTER_LEN - 1));
  assign fall        = filt_switch && filt_clk_p1;

  always_ff @(posedge clk) begin
    if (reset) begin
      filt_clk_p1 <= 1'b1;
      filt_cnt_p1 <= '0;
    end else if (kclk_s == filt_clk_p1) begin
      filt_cnt_p1 <= '0;
    end else if (filt_switch) begin
      filt_clk_p1 <= kclk_s;
      filt_cnt_p1 <= '0;
    end else begin
      filt_cnt_p1 <= filt_cnt_p1 + FCW'(1);
    end
  end

  // Stage 2: frame FSM; shift_p2 ends up as {stop, parity, D7..D0}
  state_t         state, state_nxt;
  logic [3:0]     bit_cnt, bit_cnt_nxt;
  logic [TCW-1:0] tmo_cnt, tmo_nxt;
  logic [9:0]     shift_p2;
  logic           ext_flag, ext_nxt, brk_flag, brk_nxt;
  logic           shift_en, err_nxt, push, frame_ok;

  assign frame_ok = shift_p2[9] && (^shift_p2[8:0]);

  always_comb begin
    state_nxt   = state;
    bit_cnt_nxt = bit_cnt;
    tmo_nxt     = tmo_cnt;
    ext_nxt     = ext_flag;
    brk_nxt     = brk_flag;
    shift_en    = 1'b0;
    err_nxt     = 1'b0;
    push        = 1'b0;
    case (state)
      IDLE: begin
        if (fall && !data_s) begin
          state_nxt   = SHIFT;
          bit_cnt_nxt = 4'd1;
          tmo_nxt     = '0;
        end
      end
      SHIFT: begin
        if (fall) begin
          shift_en    = 1'b1;
          bit_cnt_nxt = bit_cnt + 4'd1;
          tmo_nxt     = '0;
          if (bit_cnt == 4'd10) state_nxt = CHECK;
        end else if (tmo_cnt == TCW'(TIMEOUT_CYCLES - 1)) begin
          state_nxt = IDLE;
          err_nxt   = 1'b1;
          ext_nxt   = 1'b0;
          brk_nxt   = 1'b0;
        end else begin
          tmo_nxt = tmo_cnt + TCW'(1);
        end
      end
      CHECK: begin
        state_nxt = IDLE;
        if (!frame_ok) begin
          err_nxt = 1'b1;
          ext_nxt = 1'b0;
          brk_nxt = 1'b0;
        end else if (shift_p2[7:0] == 8'hE0) begin
          ext_nxt = 1'b1;
        end else if (shift_p2[7:0] == 8'hF0) begin
          brk_nxt = 1'b1;
        end else begin
          push    = 1'b1;
          ext_nxt = 1'b0;
          brk_nxt = 1'b0;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      bit_cnt     <= '0;
      tmo_cnt     <= '0;
      ext_flag    <= 1'b0;
      brk_flag    <= 1'b0;
      frame_error <= 1'b0;
      error_count <= '0;
    end else begin
      state       <= state_nxt;
      bit_cnt     <= bit_cnt_nxt;
      tmo_cnt     <= tmo_nxt;
      ext_flag    <= ext_nxt;
      brk_flag    <= brk_nxt;
      frame_error <= err_nxt;
      if (err_nxt) error_count <= sat_inc(error_count);
    end
  end

  always_ff @(posedge clk) begin
    if (shift_en) shift_p2 <= {data_s, shift_p2[9:1]};
  end

  // Stage 3: event FIFO, entries are {code, break, ext}
  logic [9:0]    fifo_mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [LW-1:0] level;
  logic          full, pop, push_ok;
  logic [9:0]    head;

  assign full    = (level == LW'(FIFO_DEPTH));
  assign pop     = event_valid && event_ready;
  assign push_ok = push && (!full || pop);

  always_ff @(posedge clk) begin
    if (push_ok) fifo_mem[wr_ptr] <= {shift_p2[7:0], brk_flag, ext_flag};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + PW'(1);
      if (pop)     rd_ptr <= rd_ptr + PW'(1);
      level <= level + LW'(push_ok) - LW'(pop);
      if (push && full && !pop) overflow <= 1'b1;
    end
  end

  assign head        = fifo_mem[rd_ptr];
  assign event_valid = (level != '0);
  assign event_code  = event_valid ? head[9:2] : 8'h00;
  assign event_break = event_valid && head[1];
  assign event_ext   = event_valid && head[0];
  assign fifo_level  = level;

endmodule

// File: tb/tb_ps2_rx_decoder.sv
// Directed bench for ps2_rx_decoder: bit-banged PS/2 frames, expected events queued
// as frames are sent and compared as the DUT presents them.
module tb_ps2_rx_decoder;

  localparam int SYNC_STAGES    = 2;
  localparam int FILTER_LEN     = 4;
  localparam int TIMEOUT_CYCLES = 300;
  localparam int FIFO_DEPTH     = 4;
  localparam int LAT            = SYNC_STAGES + FILTER_LEN + 1;

  logic       clk = 1'b0;
  logic       reset, key_clock, data, event_ready;
  logic       event_valid, event_break, event_ext, frame_error, overflow;
  logic [7:0] event_code, error_count;
  logic [$clog2(FIFO_DEPTH):0] fifo_level;

  int checks = 0;
  int errors = 0;
  int fe_cycles = 0;
  logic [9:0] exp_q[$];

  ps2_rx_decoder #(
    .SYNC_STAGES(SYNC_STAGES), .FILTER_LEN(FILTER_LEN),
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES), .FIFO_DEPTH(FIFO_DEPTH)
  ) dut (
    .clk(clk), .reset(reset), .key_clock(key_clock), .data(data),
    .event_valid(event_valid), .event_ready(event_ready), .event_code(event_code),
    .event_break(event_break), .event_ext(event_ext), .frame_error(frame_error),
    .error_count(error_count), .overflow(overflow), .fifo_level(fifo_level)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      if (frame_error) fe_cycles++;
    end
  endtask

  task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", name, obs, expv);
    end
  endtask

  task automatic send_bit(input logic b, input bit lat);
    data = b;
    tick(10);
    key_clock = 1'b0;
    if (lat) begin
      tick(LAT - 1);
      chk("latency_before", 32'(event_valid), 0);
      tick(1);
      chk("latency_at", 32'(event_valid), 1);
      tick(20 - LAT);
    end else begin
      tick(20);
    end
    key_clock = 1'b1;
    tick(10);
  endtask

  task automatic send_partial(input logic [7:0] code, input int nbits);
    logic [10:0] fr;
    fr = {1'b1, ~^code, code, 1'b0};
    for (int i = 0; i < nbits; i++) send_bit(fr[i], 1'b0);
  endtask

  task automatic send_frame(input logic [7:0] code, input bit bad_par, input bit lat);
    logic [10:0] fr;
    fr = {1'b1, (~^code) ^ bad_par, code, 1'b0};
    for (int i = 0; i < 10; i++) send_bit(fr[i], 1'b0);
    send_bit(fr[10], lat);
  endtask

  task automatic pop_check(input string name);
    int w;
    logic [9:0] e;
    w = 0;
    while (!event_valid && w < 200) begin
      tick(1);
      w++;
    end
    chk({name, "_valid"}, 32'(event_valid), 1);
    e = (exp_q.size() > 0) ? exp_q.pop_front() : 10'h3FF;
    chk({name, "_code"}, 32'(event_code), 32'(e[9:2]));
    chk({name, "_break"}, 32'(event_break), 32'(e[1]));
    chk({name, "_ext"}, 32'(event_ext), 32'(e[0]));
    event_ready = 1'b1;
    tick(1);
    event_ready = 1'b0;
  endtask

  initial begin
    logic [7:0] codes [5];
    codes = '{8'h15, 8'h1D, 8'h24, 8'h2D, 8'h2C};
    reset = 1'b1; key_clock = 1'b1; data = 1'b1; event_ready = 1'b0;
    tick(5);
    chk("rst_valid", 32'(event_valid), 0);
    chk("rst_code", 32'(event_code), 0);
    chk("rst_frame_error", 32'(frame_error), 0);
    chk("rst_error_count", 32'(error_count), 0);
    chk("rst_overflow", 32'(overflow), 0);
    chk("rst_level", 32'(fifo_level), 0);
    reset = 1'b0;
    tick(5);

    // single make code with latency check
    exp_q.push_back({8'h1C, 1'b0, 1'b0});
    send_frame(8'h1C, 1'b0, 1'b1);
    pop_check("t1");
    tick(2);
    chk("t1_empty", 32'(event_valid), 0);
    chk("t1_errcnt", 32'(error_count), 0);

    // break and extended-break prefixes
    send_frame(8'hF0, 1'b0, 1'b0);
    chk("t2_prefix_no_event", 32'(fifo_level), 0);
    exp_q.push_back({8'h1C, 1'b1, 1'b0});
    send_frame(8'h1C, 1'b0, 1'b0);
    chk("t2_level_a", 32'(fifo_level), 1);
    pop_check("t2a");
    send_frame(8'hE0, 1'b0, 1'b0);
    send_frame(8'hF0, 1'b0, 1'b0);
    exp_q.push_back({8'h74, 1'b1, 1'b1});
    send_frame(8'h74, 1'b0, 1'b0);
    chk("t2_level_b", 32'(fifo_level), 1);
    pop_check("t2b");

    // parity error clears a pending F0
    send_frame(8'hF0, 1'b0, 1'b0);
    fe_cycles = 0;
    send_frame(8'h1C, 1'b1, 1'b0);
    chk("t3_fe_width", 32'(fe_cycles), 1);
    chk("t3_errcnt", 32'(error_count), 1);
    chk("t3_no_event", 32'(fifo_level), 0);
    exp_q.push_back({8'h32, 1'b0, 1'b0});
    send_frame(8'h32, 1'b0, 1'b0);
    pop_check("t3");

    // timeout mid-frame
    fe_cycles = 0;
    send_partial(8'h1C, 5);
    tick(TIMEOUT_CYCLES + 50);
    chk("t4_fe_width", 32'(fe_cycles), 1);
    chk("t4_errcnt", 32'(error_count), 2);
    chk("t4_no_event", 32'(fifo_level), 0);
    exp_q.push_back({8'h1C, 1'b0, 1'b0});
    send_frame(8'h1C, 1'b0, 1'b0);
    pop_check("t4");

    // overflow with consumer stalled
    for (int i = 0; i < 5; i++) begin
      if (i < FIFO_DEPTH) exp_q.push_back({codes[i], 1'b0, 1'b0});
      send_frame(codes[i], 1'b0, 1'b0);
    end
    chk("t5_level_full", 32'(fifo_level), FIFO_DEPTH);
    chk("t5_overflow", 32'(overflow), 1);
    for (int i = 0; i < FIFO_DEPTH; i++) pop_check("t5");
    tick(1);
    chk("t5_drained", 32'(event_valid), 0);
    chk("t5_overflow_sticky", 32'(overflow), 1);

    // reset mid-frame during a glitch, then a standalone short glitch
    send_partial(8'h1C, 6);
    key_clock = 1'b0;
    reset = 1'b1;
    tick(2);
    chk("t6_rst_overflow", 32'(overflow), 0);
    chk("t6_rst_errcnt", 32'(error_count), 0);
    chk("t6_rst_level", 32'(fifo_level), 0);
    chk("t6_rst_frame_error", 32'(frame_error), 0);
    reset = 1'b0;
    tick(1);
    key_clock = 1'b1;
    tick(20);
    data = 1'b0;
    key_clock = 1'b0;
    tick(FILTER_LEN - 1);
    key_clock = 1'b1;
    tick(10);
    data = 1'b1;
    fe_cycles = 0;
    tick(20);
    exp_q.push_back({8'h1C, 1'b0, 1'b0});
    send_frame(8'h1C, 1'b0, 1'b0);
    chk("t6_level", 32'(fifo_level), 1);
    pop_check("t6");
    tick(2);
    chk("t6_empty", 32'(event_valid), 0);
    chk("t6_no_error", 32'(fe_cycles), 0);
    chk("t6_errcnt", 32'(error_count), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
